// File: rtl/carousel_dispatch.sv
// rtl/carousel_dispatch.sv - one upstream word stream dealt round-robin onto three registered lanes
// Optional CAROUSEL_DISPATCH_SKIP_EN: skip stalled lanes instead of blocking on them.
module carousel_dispatch #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [WIDTH-1:0] data_out_0,
    output logic             data_out_valid_0,
    input  logic             data_out_ready_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             data_out_valid_1,
    input  logic             data_out_ready_1,
    output logic [WIDTH-1:0] data_out_2,
    output logic             data_out_valid_2,
    input  logic             data_out_ready_2,
    output logic [1:0]       in_flight
);

    generate
        if (BUFFER_SIZE != 3) begin : g_bad_size
            $error("carousel_dispatch: BUFFER_SIZE must be 3");
        end
    endgenerate

    logic [2:0]       r_full;
    logic [WIDTH-1:0] r_data [3];
    logic [1:0]       r_ptr;
    logic [1:0]       r_in_flight;

    logic [2:0]       w_out_ready;
    logic [2:0]       w_writable;
    logic [1:0]       w_target;
    logic             w_sel_ok;
    logic             w_accept;
    logic [2:0]       w_load;
    logic [2:0]       w_full_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_ptr_p1;
    logic [1:0]       w_ptr_p2;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic f_bit(input logic [2:0] v, input logic [1:0] p);
        case (p)
            2'd0:    return v[0];
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return 1'b0;
        endcase
    endfunction

    assign w_out_ready = {data_out_ready_2, data_out_ready_1, data_out_ready_0};
    // A full lane can still take a word in the cycle it is being drained.
    assign w_writable  = ~r_full | w_out_ready;
    assign w_ptr_p1    = f_inc(r_ptr);
    assign w_ptr_p2    = f_inc(w_ptr_p1);

    always_comb begin
        w_target = r_ptr;
        w_sel_ok = 1'b0;
`ifdef CAROUSEL_DISPATCH_SKIP_EN
        if (f_bit(w_writable, r_ptr)) begin
            w_target = r_ptr;
        end else if (f_bit(w_writable, w_ptr_p1)) begin
            w_target = w_ptr_p1;
        end else begin
            w_target = w_ptr_p2;
        end
        w_sel_ok = |w_writable;
`else
        w_target = r_ptr;
        w_sel_ok = f_bit(w_writable, r_ptr);
`endif
    end

    assign data_in_ready = rst & w_sel_ok;
    assign w_accept      = data_in_valid & data_in_ready;
    assign w_ptr_nxt     = w_accept ? f_inc(w_target) : r_ptr;

    always_comb begin
        w_load     = 3'b000;
        w_full_nxt = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_load[i]     = w_accept & (w_target == 2'(i));
            w_full_nxt[i] = w_load[i] | (r_full[i] & ~w_out_ready[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full      <= 3'b000;
            r_ptr       <= 2'd0;
            r_in_flight <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_full      <= w_full_nxt;
            r_ptr       <= w_ptr_nxt;
            r_in_flight <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]} + {1'b0, w_full_nxt[2]};
            for (int i = 0; i < 3; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= data_in;
                end
            end
        end
    end

    assign data_out_0       = r_data[0];
    assign data_out_1       = r_data[1];
    assign data_out_2       = r_data[2];
    assign data_out_valid_0 = r_full[0];
    assign data_out_valid_1 = r_full[1];
    assign data_out_valid_2 = r_full[2];
    assign in_flight        = r_in_flight;

endmodule

// File: tb/tb_carousel_dispatch.sv
// tb/tb_carousel_dispatch.sv - directed self-checking bench for carousel_dispatch
module tb_carousel_dispatch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic [1:0] in_flight;
    logic [7:0] dout [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign dout[0] = d0;
    assign dout[1] = d1;
    assign dout[2] = d2;

    carousel_dispatch #(.WIDTH(8), .BUFFER_SIZE(3)) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out_0(d0), .data_out_valid_0(v0), .data_out_ready_0(r0),
        .data_out_1(d1), .data_out_valid_1(v1), .data_out_ready_1(r1),
        .data_out_2(d2), .data_out_valid_2(v2), .data_out_ready_2(r2),
        .in_flight(in_flight)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        data_in_valid = 1'b0;
        {r0, r1, r2} = 3'b000;
        #3;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        data_in_valid = 1'b1;
        data_in = 8'hEE;
        {r0, r1, r2} = 3'b111;
        #2 rst = 1'b0;
        #2;
        n_checks++; if ({v0, v1, v2} !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b want 000", {v0, v1, v2}); end
        n_checks++; if ({d0, d1, d2} !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", {d0, d1, d2}); end
        n_checks++; if (in_flight !== 2'd0) begin n_fail++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
        n_checks++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", data_in_ready); end
        tick();
        n_checks++; if ({v0, v1, v2} !== 3'b000) begin n_fail++; $display("FAIL reset_hold_valid got %b want 000", {v0, v1, v2}); end
        data_in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [7:0] words [4];
        int         lanes [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        lanes = '{0, 1, 2, 0};
        do_reset();
        {r0, r1, r2} = 3'b111;
        data_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = words[k];
            #1;
            n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready word %0d got %b want 1", k, data_in_ready); end
            tick();
            n_checks++; if ({v0, v1, v2} !== (3'b100 >> lanes[k])) begin n_fail++; $display("FAIL rr_valid word %0d got %b want %b", k, {v0, v1, v2}, 3'b100 >> lanes[k]); end
            n_checks++; if (dout[lanes[k]] !== words[k]) begin n_fail++; $display("FAIL rr_data word %0d got %h want %h", k, dout[lanes[k]], words[k]); end
            n_checks++; if (in_flight !== 2'd1) begin n_fail++; $display("FAIL rr_in_flight word %0d got %0d want 1", k, in_flight); end
        end
        data_in_valid = 1'b0;
        tick();
        n_checks++; if ({v0, v1, v2, in_flight} !== 5'b0) begin n_fail++; $display("FAIL rr_empty got %b want 00000", {v0, v1, v2, in_flight}); end
    endtask

    task automatic test_stall;
        do_reset();
        data_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = 8'hA0 + 8'(k);
            tick();
        end
        data_in = 8'hBB;
        #1;
        n_checks++; if (in_flight !== 2'd3) begin n_fail++; $display("FAIL stall_in_flight got %0d want 3", in_flight); end
        n_checks++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b want 0", data_in_ready); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++; if ({v0, v1, v2, d0, d1, d2} !== {3'b111, 24'hA0A1A2}) begin n_fail++; $display("FAIL stall_hold cycle %0d got %b %h want 111 a0a1a2", c, {v0, v1, v2}, {d0, d1, d2}); end
        end
        data_in_valid = 1'b0;
        {r0, r1, r2} = 3'b111;
        tick();
        n_checks++; if (in_flight !== 2'd0) begin n_fail++; $display("FAIL stall_drain got %0d want 0", in_flight); end
    endtask

    task automatic test_drain_and_load;
        do_reset();
        {r0, r1, r2} = 3'b011;
        data_in_valid = 1'b1;
        data_in = 8'h55; tick();
        data_in = 8'h56; tick();
        data_in = 8'h57; tick();
        {r0, r1, r2} = 3'b111;
        data_in = 8'h66;
        #1;
        n_checks++; if ({data_in_ready, v0, d0} !== {2'b11, 8'h55}) begin n_fail++; $display("FAIL dl_before got %b %b %h want 1 1 55", data_in_ready, v0, d0); end
        tick();
        n_checks++; if ({v0, d0} !== {1'b1, 8'h66}) begin n_fail++; $display("FAIL dl_after got %b %h want 1 66", v0, d0); end
        n_checks++; if (in_flight !== 2'd1) begin n_fail++; $display("FAIL dl_in_flight got %0d want 1", in_flight); end
        data_in_valid = 1'b0;
        tick();
        n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL dl_drained got %b want 0", v0); end
    endtask

    task automatic test_blocked;
        do_reset();
        {r0, r1, r2} = 3'b101;
        data_in_valid = 1'b1;
        data_in = 8'h70; tick();
        data_in = 8'h71; tick();
        data_in = 8'h72; tick();
        data_in = 8'h73; tick();
        data_in = 8'h77;
        #1;
`ifdef CAROUSEL_DISPATCH_SKIP_EN
        n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL blk_ready got %b want 1", data_in_ready); end
        tick();
        n_checks++; if ({v1, d1, v2, d2} !== {1'b1, 8'h71, 1'b1, 8'h77}) begin n_fail++; $display("FAIL blk_skip got %b %h %b %h want 1 71 1 77", v1, d1, v2, d2); end
        n_checks++; if (in_flight !== 2'd2) begin n_fail++; $display("FAIL blk_in_flight got %0d want 2", in_flight); end
        data_in = 8'h78;
        tick();
        n_checks++; if ({v0, d0} !== {1'b1, 8'h78}) begin n_fail++; $display("FAIL blk_ptr_wrap got %b %h want 1 78", v0, d0); end
`else
        n_checks++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL blk_ready got %b want 0", data_in_ready); end
        tick();
        n_checks++; if ({v0, v1, d1, v2} !== {1'b0, 1'b1, 8'h71, 1'b0}) begin n_fail++; $display("FAIL blk_held got %b %b %h %b want 0 1 71 0", v0, v1, d1, v2); end
        n_checks++; if (in_flight !== 2'd1) begin n_fail++; $display("FAIL blk_in_flight got %0d want 1", in_flight); end
        r1 = 1'b1;
        #1;
        n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL blk_release_ready got %b want 1", data_in_ready); end
        tick();
        n_checks++; if ({v1, d1} !== {1'b1, 8'h77}) begin n_fail++; $display("FAIL blk_release got %b %h want 1 77", v1, d1); end
`endif
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        do_reset();
        data_in_valid = 1'b1;
        data_in = 8'h90; tick();
        data_in = 8'h91; tick();
        data_in_valid = 1'b0;
        n_checks++; if (in_flight !== 2'd2) begin n_fail++; $display("FAIL mid_in_flight got %0d want 2", in_flight); end
        #3 rst = 1'b0;
        #1;
        n_checks++; if ({v0, v1, v2, in_flight, data_in_ready} !== 6'b0) begin n_fail++; $display("FAIL mid_async got %b want 000000", {v0, v1, v2, in_flight, data_in_ready}); end
        n_checks++; if ({d0, d1, d2} !== 24'h0) begin n_fail++; $display("FAIL mid_data got %h want 000000", {d0, d1, d2}); end
        #1 rst = 1'b1;
        {r0, r1, r2} = 3'b111;
        data_in_valid = 1'b1;
        data_in = 8'h92;
        tick();
        n_checks++; if ({v0, v1, v2, d0} !== {3'b100, 8'h92}) begin n_fail++; $display("FAIL mid_first got %b %h want 100 92", {v0, v1, v2}, d0); end
        data_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_drain_and_load();
        test_blocked();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
